// File: rtl/chess_mem_pkg.sv
// Shared constants for the chess data-memory port B clients.
package chess_mem_pkg;

  localparam int unsigned ARB_FIXED = 0;
  localparam int unsigned ARB_RR    = 1;

  localparam int unsigned DEFAULT_ADDR_W = 12;
  localparam int unsigned DEFAULT_DATA_W = 32;

endpackage

// File: rtl/arb_select.sv
// Combinational one-hot grant selection, fixed priority or round-robin from last_grant+1.
module arb_select
  import chess_mem_pkg::*;
#(
  parameter int unsigned NUM_CH = 3,
  parameter int unsigned IDX_W  = $clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [IDX_W-1:0]  last_grant,
  input  logic              mode,
  output logic [NUM_CH-1:0] gnt
);

  int unsigned       start;
  logic [IDX_W-1:0]  sel;
  logic              found;

  always_comb begin
    gnt   = '0;
    start = 0;
    sel   = '0;
    found = 1'b0;
    if (mode == 1'(ARB_RR)) begin
      start = (32'(last_grant) + 1) % NUM_CH;
    end
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      sel = IDX_W'((start + k) % NUM_CH);
      if (!found && req[sel]) begin
        gnt[sel] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dmem_port_arbiter.sv
// Serialises NUM_CH single-word clients onto memory port B and returns channel-tagged read data.
module dmem_port_arbiter
  import chess_mem_pkg::*;
#(
  parameter int unsigned NUM_CH     = 3,
  parameter int unsigned ADDR_W     = DEFAULT_ADDR_W,
  parameter int unsigned DATA_W     = DEFAULT_DATA_W,
  parameter int unsigned RD_LATENCY = 1,
  parameter int unsigned RR_MODE    = ARB_RR
) (
  input  logic                     CLOCK_50,
  input  logic                     resetn,
  input  logic [NUM_CH-1:0]        req,
  input  logic [NUM_CH-1:0]        req_we,
  input  logic [NUM_CH*ADDR_W-1:0] req_addr,
  input  logic [NUM_CH*DATA_W-1:0] req_wdata,
  output logic [NUM_CH-1:0]        gnt,
  output logic [NUM_CH-1:0]        rvalid,
  output logic [DATA_W-1:0]        rdata,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic [DATA_W-1:0]        mem_wdata,
  output logic                     mem_we,
  input  logic [DATA_W-1:0]        mem_q
);

  localparam int unsigned IDX_W = $clog2(NUM_CH);

  logic [IDX_W-1:0]  last_grant_q;
  logic [IDX_W-1:0]  grant_idx;
  logic              any_gnt;
  logic [NUM_CH-1:0] req_live;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic              sel_we;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic              mem_we_q;
  logic [NUM_CH-1:0] tag_q [RD_LATENCY+1];

  // Masking with resetn keeps gnt low for the whole reset, not just until the next edge.
  assign req_live = req & {NUM_CH{resetn}};

  arb_select #(
    .NUM_CH (NUM_CH),
    .IDX_W  (IDX_W)
  ) u_arb_select (
    .req        (req_live),
    .last_grant (last_grant_q),
    .mode       (1'(RR_MODE)),
    .gnt        (gnt)
  );

  always_comb begin
    grant_idx = '0;
    sel_addr  = '0;
    sel_wdata = '0;
    sel_we    = 1'b0;
    for (int i = 0; i < int'(NUM_CH); i++) begin
      if (gnt[i]) begin
        grant_idx = IDX_W'(i);
        sel_addr  = req_addr[i*ADDR_W +: ADDR_W];
        sel_wdata = req_wdata[i*DATA_W +: DATA_W];
        sel_we    = req_we[i];
      end
    end
  end

  assign any_gnt = |gnt;

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      last_grant_q <= IDX_W'(NUM_CH - 1);
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_we_q     <= 1'b0;
    end else begin
      mem_we_q <= any_gnt & sel_we;
      if (any_gnt) begin
        last_grant_q <= grant_idx;
        mem_addr_q   <= sel_addr;
        mem_wdata_q  <= sel_wdata;
      end
    end
  end

  // Tag travels alongside the memory read so the output lines up with mem_q.
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i <= int'(RD_LATENCY); i++) begin
        tag_q[i] <= '0;
      end
    end else begin
      tag_q[0] <= gnt & ~req_we;
      for (int i = 1; i <= int'(RD_LATENCY); i++) begin
        tag_q[i] <= tag_q[i-1];
      end
    end
  end

  assign rvalid    = tag_q[RD_LATENCY];
  assign rdata     = mem_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_we    = mem_we_q;

endmodule
